// File: rtl/mac_table_manage.sv
// 32-entry MAC forwarding table: learn writes, 1-cycle DMAC lookup,
// and background aging of stale entries.
module mac_table_manage #(
  parameter int         ADDR_W          = 5,
  parameter int         AGE_TICK_CYCLES = 125000000,
  parameter int         AGE_W           = 4,
  parameter int         AGE_MAX         = 10,
  parameter logic [8:0] FLOOD_PORTS     = 9'h1FF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [56:0]              iv_smac_inport,
  input  logic [ADDR_W-1:0]        iv_entry_addr,
  input  logic                     i_mactable_wr,
  input  logic [47:0]              iv_dmac,
  input  logic                     i_lookup_req,
  input  logic                     i_age_en,
  output logic [8:0]               ov_outport,
  output logic                     o_lookup_hit,
  output logic                     o_lookup_ack,
  output logic [(1<<ADDR_W)-1:0]   ov_entry_valid
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = $clog2(AGE_TICK_CYCLES);
  localparam logic [PW-1:0]    PS_LAST = PW'(AGE_TICK_CYCLES - 1);
  localparam logic [AGE_W-1:0] AGE_TOP = AGE_W'(AGE_MAX);

  logic [47:0]      mac_q  [DEPTH];
  logic [8:0]       port_q [DEPTH];
  logic [AGE_W-1:0] age_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    presc_q;

  logic              tick;
  logic [DEPTH-1:0]  match;
  logic              any_match;
  logic [ADDR_W-1:0] win;

  assign tick = i_age_en && (presc_q == PS_LAST);

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++)
      match[i] = valid_q[i] && (mac_q[i] == iv_dmac);
  end

  // scan downward so the lowest matching index is the last one kept
  always_comb begin
    win = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (match[i]) win = ADDR_W'(i);
  end

  assign any_match = |match;

  always_ff @(posedge i_clk) begin
    if (i_mactable_wr) begin
      mac_q[iv_entry_addr]  <= iv_smac_inport[56:9];
      port_q[iv_entry_addr] <= iv_smac_inport[8:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      presc_q      <= '0;
      valid_q      <= '0;
      ov_outport   <= '0;
      o_lookup_hit <= 1'b0;
      o_lookup_ack <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        age_q[i] <= '0;
    end else begin
      if (i_age_en)
        presc_q <= tick ? '0 : presc_q + 1'b1;

      // a learn write beats an aging tick on the same entry
      for (int i = 0; i < DEPTH; i++) begin
        if (i_mactable_wr && iv_entry_addr == ADDR_W'(i)) begin
          valid_q[i] <= 1'b1;
          age_q[i]   <= '0;
        end else if (tick && valid_q[i]) begin
          if (age_q[i] >= AGE_TOP)
            valid_q[i] <= 1'b0;
          else
            age_q[i] <= age_q[i] + 1'b1;
        end
      end

      o_lookup_ack <= i_lookup_req;
      if (i_lookup_req) begin
        if (iv_dmac[40] || !any_match) begin
          o_lookup_hit <= 1'b0;
          ov_outport   <= FLOOD_PORTS;
        end else begin
          o_lookup_hit <= 1'b1;
          ov_outport   <= port_q[win];
        end
      end
    end
  end

  assign ov_entry_valid = valid_q;

endmodule

// File: tb/tb_mac_table_manage.sv
// Bench for mac_table_manage: directed scenarios plus random traffic
// against a tick-count reference model of the table.
module tb_mac_table_manage;
  localparam int T  = 10;
  localparam int AM = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [56:0] smac_inport = '0;
  logic [4:0]  entry_addr = '0;
  logic        wr = 1'b0;
  logic [47:0] dmac = '0;
  logic        lookup_req = 1'b0;
  logic        age_en = 1'b0;
  logic [8:0]  outport;
  logic        hit;
  logic        ack;
  logic [31:0] entry_valid;

  int errors = 0;
  int checks = 0;

  logic [47:0] m_mac  [32];
  logic [8:0]  m_port [32];
  bit          m_wr   [32];
  int unsigned m_wt   [32];
  int unsigned en_count = 0;
  int unsigned tcount = 0;
  bit          last_tick = 0;
  bit          e_ack = 0;
  bit          e_hit = 0;
  logic [8:0]  e_port = '0;

  always #5 clk = ~clk;

  mac_table_manage #(
    .ADDR_W(5), .AGE_TICK_CYCLES(T), .AGE_W(4),
    .AGE_MAX(AM), .FLOOD_PORTS(9'h1FF)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .iv_smac_inport(smac_inport),
    .iv_entry_addr(entry_addr),
    .i_mactable_wr(wr),
    .iv_dmac(dmac),
    .i_lookup_req(lookup_req),
    .i_age_en(age_en),
    .ov_outport(outport),
    .o_lookup_hit(hit),
    .o_lookup_ack(ack),
    .ov_entry_valid(entry_valid)
  );

  // an entry lives until more than AM ticks have passed since its write
  function automatic bit m_valid(input int i);
    return m_wr[i] && ((tcount - m_wt[i]) <= AM);
  endfunction

  function automatic logic [31:0] m_vbits();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_valid(i);
    return v;
  endfunction

  task automatic m_lookup(input logic [47:0] d,
                          output bit h, output logic [8:0] p);
    h = 0;
    p = 9'h1FF;
    if (!d[40]) begin
      for (int i = 0; i < 32; i++) begin
        if (m_valid(i) && m_mac[i] == d) begin
          h = 1;
          p = m_port[i];
          break;
        end
      end
    end
  endtask

  task automatic cycle();
    bit tk;
    bit h;
    logic [8:0] p;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_wr[i] = 0;
      en_count = 0;
      tcount = 0;
      last_tick = 0;
      e_ack = 0;
      e_hit = 0;
      e_port = '0;
    end else begin
      if (lookup_req) begin
        m_lookup(dmac, h, p);
        e_ack = 1;
        e_hit = h;
        e_port = p;
      end else begin
        e_ack = 0;
      end
      tk = age_en && ((en_count % T) == T - 1);
      if (age_en) en_count++;
      if (tk) tcount++;
      last_tick = tk;
      if (wr) begin
        m_mac[entry_addr]  = smac_inport[56:9];
        m_port[entry_addr] = smac_inport[8:0];
        m_wr[entry_addr]   = 1;
        m_wt[entry_addr]   = tcount;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wr = 0;
    lookup_req = 0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [47:0] m,
                          input logic [8:0] p);
    wr = 1;
    entry_addr = a;
    smac_inport = {m, p};
  endtask

  task automatic do_look(input logic [47:0] d);
    lookup_req = 1;
    dmac = d;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    age_en = 0;
    repeat (2) cycle();
    rst_n = 1;
    checks++;
    if ({ack, hit, outport, entry_valid} !== {1'b0, 1'b0, 9'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset: ack=%b hit=%b port=%h valid=%h want all zero",
               ack, hit, outport, entry_valid);
    end
  endtask

  task automatic test_write_lookup();
    age_en = 0;
    do_write(5'd3, 48'h0011_2233_4455, 9'h004);
    cycle();
    idle();
    do_look(48'h0011_2233_4455);
    cycle();
    idle();
    checks++;
    if ({ack, hit, outport, entry_valid} !== {1'b1, 1'b1, 9'h004, 32'h8}) begin
      errors++;
      $display("FAIL write_hit: ack=%b hit=%b port=%h valid=%h want 1 1 004 00000008",
               ack, hit, outport, entry_valid);
    end
    cycle();
    checks++;
    if ({ack, hit, outport} !== {1'b0, 1'b1, 9'h004}) begin
      errors++;
      $display("FAIL hold_idle: ack=%b hit=%b port=%h want 0 1 004",
               ack, hit, outport);
    end
  endtask

  task automatic test_miss_bcast();
    age_en = 0;
    do_look(48'h0000_0000_0099);
    cycle();
    idle();
    checks++;
    if ({ack, hit, outport} !== {1'b1, 1'b0, 9'h1FF}) begin
      errors++;
      $display("FAIL miss: ack=%b hit=%b port=%h want 1 0 1ff", ack, hit, outport);
    end
    do_write(5'd0, 48'hFFFF_FFFF_FFFF, 9'h001);
    cycle();
    idle();
    do_look(48'hFFFF_FFFF_FFFF);
    cycle();
    idle();
    checks++;
    if ({ack, hit, outport} !== {1'b1, 1'b0, 9'h1FF}) begin
      errors++;
      $display("FAIL bcast: ack=%b hit=%b port=%h want 1 0 1ff", ack, hit, outport);
    end
  endtask

  task automatic test_priority();
    logic [47:0] m;
    logic [47:0] n;
    m = 48'h00AB_CDEF_0102;
    n = 48'h0012_3456_789A;
    age_en = 0;
    do_write(5'd5, m, 9'h002);
    cycle();
    do_write(5'd2, m, 9'h010);
    cycle();
    idle();
    do_look(m);
    cycle();
    idle();
    checks++;
    if ({ack, hit, outport} !== {1'b1, 1'b1, 9'h010}) begin
      errors++;
      $display("FAIL lowest_idx: ack=%b hit=%b port=%h want 1 1 010", ack, hit, outport);
    end
    do_write(5'd10, n, 9'h080);
    do_look(n);
    cycle();
    idle();
    checks++;
    if ({ack, hit, outport} !== {1'b1, 1'b0, 9'h1FF}) begin
      errors++;
      $display("FAIL wr_same_cycle: ack=%b hit=%b port=%h want 1 0 1ff", ack, hit, outport);
    end
    do_look(n);
    cycle();
    idle();
    checks++;
    if ({ack, hit, outport} !== {1'b1, 1'b1, 9'h080}) begin
      errors++;
      $display("FAIL wr_next_cycle: ack=%b hit=%b port=%h want 1 1 080", ack, hit, outport);
    end
  endtask

  task automatic test_aging();
    logic [47:0] a7;
    bit ok;
    int tk;
    a7 = 48'h0077_0000_0007;
    age_en = 1;
    idle();
    ok = 0;
    for (int k = 0; k < 3 * T; k++) begin
      cycle();
      if (last_tick) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL tick_align: no tick seen want one"); end
    do_write(5'd7, a7, 9'h040);
    cycle();
    idle();
    tk = 0;
    for (int k = 0; k < 8 * T && tk <= AM; k++) begin
      cycle();
      if (last_tick) begin
        tk++;
        checks++;
        if (entry_valid[7] !== (tk <= AM)) begin
          errors++;
          $display("FAIL age_tick%0d: valid7=%b want %b", tk, entry_valid[7], tk <= AM);
        end
      end
    end
    checks++;
    if (tk != AM + 1) begin errors++; $display("FAIL age_bound: ticks=%0d want %0d", tk, AM + 1); end
    do_look(a7);
    cycle();
    idle();
    checks++;
    if ({ack, hit, outport} !== {1'b1, 1'b0, 9'h1FF}) begin
      errors++;
      $display("FAIL aged_miss: ack=%b hit=%b port=%h want 1 0 1ff", ack, hit, outport);
    end
    do_write(5'd7, a7, 9'h040);
    cycle();
    idle();
    tk = 0;
    for (int k = 0; k < 8 * T && tk < AM; k++) begin
      cycle();
      if (last_tick) tk++;
    end
    for (int k = 0; k < 2 * T && (en_count % T) != T - 1; k++) cycle();
    do_write(5'd7, a7, 9'h040);
    cycle();
    idle();
    checks++;
    if (entry_valid[7] !== 1'b1 || !last_tick) begin
      errors++;
      $display("FAIL wr_on_tick: valid7=%b tick=%b want 1 1", entry_valid[7], last_tick);
    end
    tk = 0;
    for (int k = 0; k < 8 * T && tk <= AM; k++) begin
      cycle();
      if (last_tick) begin
        tk++;
        checks++;
        if (entry_valid[7] !== (tk <= AM)) begin
          errors++;
          $display("FAIL reage_tick%0d: valid7=%b want %b", tk, entry_valid[7], tk <= AM);
        end
      end
    end
  endtask

  task automatic test_freeze();
    age_en = 1;
    do_write(5'd9, 48'h0099_0000_0009, 9'h008);
    cycle();
    idle();
    repeat (13) cycle();
    age_en = 0;
    for (int k = 0; k < 100; k++) begin
      cycle();
      checks++;
      if (entry_valid !== m_vbits()) begin
        errors++;
        $display("FAIL freeze: valid=%h want %h", entry_valid, m_vbits());
      end
    end
    checks++;
    if (entry_valid[9] !== 1'b1) begin
      errors++;
      $display("FAIL freeze_hold: valid9=%b want 1", entry_valid[9]);
    end
    age_en = 1;
    for (int k = 0; k < 6 * T; k++) begin
      cycle();
      checks++;
      if (entry_valid !== m_vbits()) begin
        errors++;
        $display("FAIL resume: valid=%h want %h", entry_valid, m_vbits());
      end
    end
    checks++;
    if (entry_valid[9] !== 1'b0) begin
      errors++;
      $display("FAIL resume_expire: valid9=%b want 0", entry_valid[9]);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] d [4];
    bit          h [4];
    logic [8:0]  p [4];
    d[0] = 48'h00AA_0000_00A1; h[0] = 1; p[0] = 9'h020;
    d[1] = 48'h0000_0000_0055; h[1] = 0; p[1] = 9'h1FF;
    d[2] = 48'h00BB_0000_00B2; h[2] = 1; p[2] = 9'h100;
    d[3] = 48'hFFFF_FFFF_FFFF; h[3] = 0; p[3] = 9'h1FF;
    age_en = 0;
    do_write(5'd1, d[0], 9'h020);
    cycle();
    do_write(5'd4, d[2], 9'h100);
    cycle();
    idle();
    do_look(d[0]);
    cycle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({ack, hit, outport} !== {1'b1, h[k], p[k]}) begin
        errors++;
        $display("FAIL b2b%0d: ack=%b hit=%b port=%h want 1 %b %h",
                 k, ack, hit, outport, h[k], p[k]);
      end
      if (k < 3) do_look(d[k + 1]);
      else idle();
      cycle();
    end
  endtask

  task automatic test_random();
    logic [47:0] mac;
    for (int k = 0; k < 400; k++) begin
      wr = ($urandom % 3) == 0;
      entry_addr = 5'($urandom % 32);
      mac = 48'h00AA_0000_0000 | 48'($urandom % 8);
      if ($urandom % 8 == 0) mac = mac | 48'h0100_0000_0000;
      smac_inport = {mac, 9'($urandom)};
      lookup_req = ($urandom % 4) != 0;
      mac = 48'h00AA_0000_0000 | 48'($urandom % 9);
      if ($urandom % 8 == 0) mac = mac | 48'h0100_0000_0000;
      dmac = mac;
      age_en = ($urandom % 8) != 0;
      cycle();
      checks++;
      if ({ack, hit, outport, entry_valid} !== {e_ack, e_hit, e_port, m_vbits()}) begin
        errors++;
        $display("FAIL rand%0d: ack=%b hit=%b port=%h valid=%h want %b %b %h %h",
                 k, ack, hit, outport, entry_valid, e_ack, e_hit, e_port, m_vbits());
      end
    end
    idle();
  endtask

  task automatic test_reset_inflight();
    age_en = 0;
    do_write(5'd6, 48'h0066_0000_0006, 9'h004);
    cycle();
    idle();
    do_look(48'h0066_0000_0006);
    rst_n = 0;
    cycle();
    rst_n = 1;
    idle();
    checks++;
    if ({ack, hit, outport, entry_valid} !== {1'b0, 1'b0, 9'h0, 32'h0}) begin
      errors++;
      $display("FAIL rst_inflight: ack=%b hit=%b port=%h valid=%h want all zero",
               ack, hit, outport, entry_valid);
    end
    cycle();
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_ack: ack=%b want 0", ack);
    end
  endtask

  initial begin
    test_reset();
    test_write_lookup();
    test_miss_bcast();
    test_priority();
    test_aging();
    test_freeze();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_table_manage.md
Name: mac_table_manage

Overview:
- 32-entry MAC forwarding table, directly downstream of the MAC self-learning stage.
- Consumes its learn writes ({SMAC, inport}, entry address, write strobe) and stores them with a valid bit and an age counter.
- Serves single-cycle-issue DMAC lookups from the forwarding stage and returns the output-port bitmap, or a flood bitmap on a miss.
- Publishes the entry-valid bitmap back to the learning stage. Background aging removes stale entries.

Parameters:
- ADDR_W, 5, entry address width; table depth = 2^ADDR_W = 32.
- AGE_TICK_CYCLES, 125000000, clock cycles per aging tick (1 s at 125 MHz); must be >= 2.
- AGE_W, 4, age counter width.
- AGE_MAX, 10, max age value; must be < 2^AGE_W.
- FLOOD_PORTS, 9'h1FF, port bitmap returned on a miss, broadcast or multicast.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- iv_smac_inport  in  57  learn data: [56:9] SMAC, [8:0] inport bitmap.
- iv_entry_addr  in  5  learn target entry.
- i_mactable_wr  in  1  learn write strobe, one cycle per write.
- iv_dmac  in  48  lookup key.
- i_lookup_req  in  1  lookup request pulse; one may be issued every cycle.
- i_age_en  in  1  1 = aging enabled; 0 = prescaler and ages frozen.
- ov_outport  out  9  lookup result port bitmap.
- o_lookup_hit  out  1  result came from a valid table entry.
- o_lookup_ack  out  1  result valid strobe.
- ov_entry_valid  out  32  per-entry valid bitmap.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - All valid bits, ages and the prescaler are cleared.
  - Outputs: ov_outport=0, o_lookup_hit=0, o_lookup_ack=0, ov_entry_valid=0.
  - Stored MAC/port data need not be cleared.
  - A lookup or write in flight during reset is dropped; no ack is produced.
- Write:
  - When i_mactable_wr=1, entry[iv_entry_addr] is loaded from iv_smac_inport, with valid=1 and age=0.
  - The write is visible in ov_entry_valid and to lookups from the next cycle.
  - Overwriting a valid entry is allowed, with no check.
- Lookup pipeline (latency 1):
  - A request in cycle N produces o_lookup_ack=1 in cycle N+1 for exactly one cycle. Back-to-back requests give back-to-back acks.
  - iv_dmac is compared in parallel against all valid entries; the match is on the 48-bit MAC only.
  - If more than one entry matches, the lowest-index matching entry wins.
  - On a hit: o_lookup_hit=1 and ov_outport = that entry's [8:0].
  - On a miss: o_lookup_hit=0 and ov_outport=FLOOD_PORTS.
  - If iv_dmac[40]=1 (group bit, which includes broadcast), the result is forced: o_lookup_hit=0 and ov_outport=FLOOD_PORTS, regardless of table contents.
  - A lookup in the same cycle as a write sees the pre-write table state.
  - With no request, o_lookup_ack=0. ov_outport and o_lookup_hit hold their last values.
  - A lookup hit does not refresh age.
- Aging:
  - While i_age_en=1, the prescaler counts 0..AGE_TICK_CYCLES-1 and wraps. The cycle at the wrap is a tick.
  - On a tick, for each valid entry:
    - if age < AGE_MAX, age = age+1;
    - if age == AGE_MAX, valid is cleared.
  - Result: an entry that is never refreshed is invalidated on the (AGE_MAX+1)th tick after its write.
  - Ages saturate; they never wrap.
  - While i_age_en=0, the prescaler and ages hold.
- Simultaneous events:
  - A write and a tick on the same entry in the same cycle: the write wins (valid=1, age=0).
  - Other entries age normally in that cycle.
- ov_entry_valid is driven directly from the valid-bit registers.

Test Plan:
1. Reset, then write addr 3 = {48'h0011_2233_4455, 9'h004}. Next cycle, look up DMAC 0011_2233_4455 -> the cycle after the request: ack=1, hit=1, outport=9'h004, ov_entry_valid=32'h0000_0008.
2. Look up unknown DMAC 0000_0000_0099 -> ack=1, hit=0, outport=9'h1FF. Look up FF:FF:FF:FF:FF:FF with the same MAC also learned in entry 0 -> hit=0, outport=9'h1FF.
3. Same SMAC written to entries 5 (port 9'h002) and 2 (port 9'h010) -> lookup returns hit=1, outport=9'h010. Write and lookup of a new MAC in the same cycle -> miss; repeat next cycle -> hit.
4. AGE_TICK_CYCLES=10, AGE_MAX=3, i_age_en=1:
   - entry 7 written just after a tick -> still valid after ticks 1-3, valid bit cleared at tick 4, and the next lookup misses;
   - rewriting entry 7 in the tick cycle keeps valid=1 with age=0.
5. i_age_en=0 for 100 cycles -> no entry ages. Re-enabling resumes from the held prescaler value.
6. Four back-to-back lookups (hit, miss, hit, broadcast) -> four consecutive acks with the matching results. Assert i_rst_n=0 in the cycle of a request -> no ack, and ov_entry_valid=0 the next cycle.
